// File: rtl/age_request_scheduler_pkg.sv
// Shared constants and entry type for the age-based request scheduler.
// Imported by the selector and the scheduler top.
package age_request_scheduler_pkg;

  localparam int BUFF_LEN = 8;
  localparam int AGE_W    = 16;
  localparam int BANK_W   = 4;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 3;

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
    logic [AGE_W-1:0]  age;
    logic [DATA_W-1:0] data;
  } sched_entry_t;

  function automatic logic [AGE_W-1:0] age_inc(
    input logic [AGE_W-1:0] a
  );
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/age_request_scheduler_calcmax.sv
// CalcMax: combinational max-selector over the eight age keys.
// A later key must be strictly greater to win, so ties keep the lower index.
module CalcMax
  import age_request_scheduler_pkg::*;
(
  input  logic [BUFF_LEN-1:0][AGE_W-1:0] keys,
  output logic [IDX_W-1:0]               max_idx,
  output logic [AGE_W-1:0]               max_val
);

  always_comb begin
    max_idx = '0;
    max_val = keys[0];
    for (int i = 1; i < BUFF_LEN; i++) begin
      if (keys[i] > max_val) begin
        max_idx = IDX_W'(i);
        max_val = keys[i];
      end
    end
  end

endmodule

// File: rtl/age_request_scheduler.sv
// Eight-entry age-ordered request buffer with a registered issue stage.
// Picks the oldest request whose bank is free and hands it downstream.
module age_request_scheduler
  import age_request_scheduler_pkg::*;
#(
  parameter int BuffLength = 8,
  parameter int DataWidth  = 32,
  parameter int AgeWidth   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_bank,
  input  logic [DataWidth-1:0] in_data,
  input  logic [15:0]          bank_busy,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [3:0]           issue_bank,
  output logic [DataWidth-1:0] issue_data,
  output logic [AgeWidth-1:0]  issue_age,
  output logic [3:0]           occupancy
);

  if (BuffLength != BUFF_LEN) begin : g_bad_len
    $error("BuffLength must be 8");
  end
  if (DataWidth != DATA_W) begin : g_bad_data
    $error("DataWidth must be 32");
  end
  if (AgeWidth != AGE_W) begin : g_bad_age
    $error("AgeWidth must match CalcMax");
  end

  sched_entry_t entry_q [BUFF_LEN];
  sched_entry_t entry_d [BUFF_LEN];

  logic [3:0]        occ_q, occ_d;
  logic              iss_valid_q, iss_valid_d;
  logic [BANK_W-1:0] iss_bank_q, iss_bank_d;
  logic [DATA_W-1:0] iss_data_q, iss_data_d;
  logic [AGE_W-1:0]  iss_age_q, iss_age_d;

  logic [BUFF_LEN-1:0][AGE_W-1:0] keys;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] free_idx;
  logic [AGE_W-1:0] sel_key;
  logic             elig_any;
  logic             push;
  logic             load;

  assign in_ready = (occ_q != 4'd8);
  assign push     = in_valid && in_ready;

  // Scanning downward leaves the lowest invalid index in free_idx.
  always_comb begin
    free_idx = '0;
    for (int i = BUFF_LEN - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < BUFF_LEN; i++) begin
      keys[i] = (entry_q[i].valid && !bank_busy[entry_q[i].bank])
              ? entry_q[i].age : '0;
    end
  end

  CalcMax u_sel (
    .keys    (keys),
    .max_idx (sel),
    .max_val (sel_key)
  );

  assign elig_any = (sel_key != '0);
  assign load     = elig_any && (!iss_valid_q || issue_ready);

  always_comb begin
    for (int i = 0; i < BUFF_LEN; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        entry_d[i].age = age_inc(entry_q[i].age);
      end
      if (load && (sel == IDX_W'(i))) begin
        entry_d[i] = '0;
      end
      if (push && (free_idx == IDX_W'(i))) begin
        entry_d[i].valid = 1'b1;
        entry_d[i].bank  = in_bank;
        entry_d[i].age   = AGE_W'(1);
        entry_d[i].data  = in_data;
      end
    end
  end

  assign occ_d = occ_q + {3'b000, push} - {3'b000, load};

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_bank_d  = iss_bank_q;
    iss_data_d  = iss_data_q;
    iss_age_d   = iss_age_q;
    if (load) begin
      iss_valid_d = 1'b1;
      iss_bank_d  = entry_q[sel].bank;
      iss_data_d  = entry_q[sel].data;
      iss_age_d   = entry_q[sel].age;
    end else if (iss_valid_q && issue_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUFF_LEN; i++) begin
        entry_q[i] <= '0;
      end
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_bank_q  <= '0;
      iss_data_q  <= '0;
      iss_age_q   <= '0;
    end else begin
      for (int i = 0; i < BUFF_LEN; i++) begin
        entry_q[i] <= entry_d[i];
      end
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      iss_bank_q  <= iss_bank_d;
      iss_data_q  <= iss_data_d;
      iss_age_q   <= iss_age_d;
    end
  end

  assign issue_valid = iss_valid_q;
  assign issue_bank  = iss_bank_q;
  assign issue_data  = iss_data_q;
  assign issue_age   = iss_age_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_age_request_scheduler.sv
// Directed self-checking bench for age_request_scheduler.
// Each scenario task drives stimulus and checks hand-computed results.
module tb_age_request_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_bank;
  logic [31:0] in_data;
  logic [15:0] bank_busy;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_bank;
  logic [31:0] issue_data;
  logic [15:0] issue_age;
  logic [3:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  age_request_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bank     (in_bank),
    .in_data     (in_data),
    .bank_busy   (bank_busy),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_bank  (issue_bank),
    .issue_data  (issue_data),
    .issue_age   (issue_age),
    .occupancy   (occupancy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_bank  = '0;
    in_data  = '0;
    reset    = 1'b1;
    #2;
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    in_valid    = 1'b0;
    in_bank     = '0;
    in_data     = '0;
    bank_busy   = '0;
    issue_ready = 1'b1;
    reset       = 1'b1;
    #12;
    reset       = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset issue_valid got %b want 0", issue_valid);
    end
    n_cmp++;
    if (issue_bank !== 4'd0 || issue_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset issue_bank/data got %h/%h want 0/0",
               issue_bank, issue_data);
    end
    n_cmp++;
    if (issue_age !== 16'd0) begin
      n_err++;
      $display("FAIL reset issue_age got %h want 0", issue_age);
    end
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_err++;
      $display("FAIL reset occupancy got %0d want 0", occupancy);
    end
  endtask

  task automatic test_single(input string tag);
    issue_ready = 1'b1;
    bank_busy   = '0;
    in_valid    = 1'b1;
    in_bank     = 4'd3;
    in_data     = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 4'd1 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s edge1 occ/valid got %0d/%b want 1/0",
               tag, occupancy, issue_valid);
    end
    tick();
    n_cmp++;
    if (issue_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s issue_valid got %b want 1", tag, issue_valid);
    end
    n_cmp++;
    if (issue_bank !== 4'd3) begin
      n_err++;
      $display("FAIL %s issue_bank got %0d want 3", tag, issue_bank);
    end
    n_cmp++;
    if (issue_data !== 32'hA5A5_0001) begin
      n_err++;
      $display("FAIL %s issue_data got %h want a5a50001",
               tag, issue_data);
    end
    n_cmp++;
    if (issue_age !== 16'd1) begin
      n_err++;
      $display("FAIL %s issue_age got %0d want 1", tag, issue_age);
    end
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_err++;
      $display("FAIL %s occ got %0d want 0", tag, occupancy);
    end
    tick();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s drain issue_valid got %b want 0",
               tag, issue_valid);
    end
  endtask

  task automatic test_fill();
    int  acc;
    logic rdy;
    acc = 0;
    issue_ready = 1'b0;
    bank_busy   = '0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_bank  = 4'(acc);
      in_data  = 32'hD000_0000 + 32'(acc);
      rdy      = in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc != 9) begin
      n_err++;
      $display("FAIL fill accepted got %0d want 9", acc);
    end
    n_cmp++;
    if (occupancy !== 4'd8) begin
      n_err++;
      $display("FAIL fill occ got %0d want 8", occupancy);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill in_ready got %b want 0", in_ready);
    end
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_data !== 32'hD000_0000) begin
      n_err++;
      $display("FAIL fill issue v/data got %b/%h want 1/d0000000",
               issue_valid, issue_data);
    end
    n_cmp++;
    if (issue_age !== 16'd1) begin
      n_err++;
      $display("FAIL fill issue_age got %0d want 1", issue_age);
    end
  endtask

  task automatic test_full_enqueue();
    in_valid    = 1'b1;
    in_bank     = 4'd7;
    in_data     = 32'hE000_00EE;
    issue_ready = 1'b1;
    tick();
    n_cmp++;
    if (occupancy !== 4'd7) begin
      n_err++;
      $display("FAIL full_enq occ got %0d want 7", occupancy);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_enq in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_data !== 32'hD000_0001) begin
      n_err++;
      $display("FAIL full_enq issue v/data got %b/%h want 1/d0000001",
               issue_valid, issue_data);
    end
    issue_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 4'd8 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_enq refill occ/rdy got %0d/%b want 8/0",
               occupancy, in_ready);
    end
    n_cmp++;
    if (dut.entry_q[1].valid !== 1'b1 ||
        dut.entry_q[1].data !== 32'hE000_00EE) begin
      n_err++;
      $display("FAIL full_enq slot1 v/data got %b/%h want 1/e00000ee",
               dut.entry_q[1].valid, dut.entry_q[1].data);
    end
    n_cmp++;
    if (issue_data !== 32'hD000_0001) begin
      n_err++;
      $display("FAIL full_enq hold data got %h want d0000001",
               issue_data);
    end
  endtask

  task automatic test_bank_busy();
    do_reset();
    issue_ready = 1'b1;
    bank_busy   = 16'hFFFF;
    in_valid = 1'b1;
    in_bank  = 4'd5;
    in_data  = 32'hB000_0005;
    tick();
    in_valid = 1'b0;
    repeat (39) tick();
    in_valid = 1'b1;
    in_bank  = 4'd2;
    in_data  = 32'hB000_0002;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if (occupancy !== 4'd2 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL busy pre occ/valid got %0d/%b want 2/0",
               occupancy, issue_valid);
    end
    bank_busy = 16'h0020;
    tick();
    n_cmp++;
    if (issue_bank !== 4'd2 || issue_age !== 16'd10) begin
      n_err++;
      $display("FAIL busy first bank/age got %0d/%0d want 2/10",
               issue_bank, issue_age);
    end
    n_cmp++;
    if (issue_data !== 32'hB000_0002 || issue_valid !== 1'b1) begin
      n_err++;
      $display("FAIL busy first data/v got %h/%b want b0000002/1",
               issue_data, issue_valid);
    end
    bank_busy = 16'h0000;
    tick();
    n_cmp++;
    if (issue_bank !== 4'd5 || issue_age !== 16'd51) begin
      n_err++;
      $display("FAIL busy second bank/age got %0d/%0d want 5/51",
               issue_bank, issue_age);
    end
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_err++;
      $display("FAIL busy end occ got %0d want 0", occupancy);
    end
  endtask

  task automatic test_reset_async();
    do_reset();
    issue_ready = 1'b0;
    bank_busy   = '0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_bank  = 4'(k);
      in_data  = 32'hC000_0000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (occupancy !== 4'd5 || issue_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset pre occ/valid got %0d/%b want 5/1",
               occupancy, issue_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
      n_err++;
      $display("FAIL areset valid/occ got %b/%0d want 0/0",
               issue_valid, occupancy);
    end
    n_cmp++;
    if (issue_bank !== 4'd0 || issue_data !== 32'd0 ||
        issue_age !== 16'd0) begin
      n_err++;
      $display("FAIL areset bank/data/age got %h/%h/%h want 0/0/0",
               issue_bank, issue_data, issue_age);
    end
    #2;
    reset = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL areset in_ready got %b want 1", in_ready);
    end
    test_single("post_reset");
  endtask

  task automatic test_saturation();
    do_reset();
    issue_ready = 1'b1;
    bank_busy   = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_bank  = (k == 1 || k == 6) ? 4'd9 : 4'd0;
      in_data  = 32'h5A70_0000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    repeat (65540) tick();
    n_cmp++;
    if (occupancy !== 4'd8 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sat pre occ/valid got %0d/%b want 8/0",
               occupancy, issue_valid);
    end
    bank_busy = ~16'h0200;
    tick();
    n_cmp++;
    if (issue_data !== 32'h5A70_0001 || issue_age !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat first data/age got %h/%h want 5a700001/ffff",
               issue_data, issue_age);
    end
    tick();
    n_cmp++;
    if (issue_data !== 32'h5A70_0006 || issue_age !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat second data/age got %h/%h want 5a700006/ffff",
               issue_data, issue_age);
    end
    tick();
    n_cmp++;
    if (issue_valid !== 1'b0 || occupancy !== 4'd6) begin
      n_err++;
      $display("FAIL sat end valid/occ got %b/%0d want 0/6",
               issue_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_fill();
    test_full_enqueue();
    test_bank_busy();
    test_reset_async();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
